// File: rtl/accum_pkg.sv
// Shared encodings for the accumulator unit: ALU ops, next-value selects and
// the multiply sequencer states.
package accum_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_SHL  = 3'b100,
    OP_SHR  = 3'b101,
    OP_MUL  = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ASEL_ALU  = 2'b00,
    ASEL_EXT  = 2'b01,
    ASEL_DATA = 2'b10,
    ASEL_HOLD = 2'b11
  } asel_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/accum_alu.sv
// Single-cycle ALU for the accumulator: result plus carry/overflow flags.
// MUL is not handled here; it falls through to ADD for builds without a multiplier.
module accum_alu
  import accum_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (op)
      OP_ADD, OP_MUL: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
        ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result = diff[WIDTH-1:0];
        // diff[WIDTH] is the borrow, so carry reports A >= B unsigned.
        carry  = ~diff[WIDTH];
        ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_SHL: begin
        result = {a[WIDTH-2:0], 1'b0};
        carry  = a[WIDTH-1];
      end
      OP_SHR: begin
        result = {1'b0, a[WIDTH-1:1]};
        carry  = a[0];
      end
      OP_PASS: result = b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/accum_unit.sv
// Accumulator register with load mux, single-cycle ALU, iterative shift-and-add
// multiplier (busy/done handshake), status flags and an output register.
module accum_unit
  import accum_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] ext_in,
  input  logic [1:0]       a_sel,
  input  logic [2:0]       op,
  input  logic             a_load,
  input  logic             out_load,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] out_q,
  output logic             a_eq0,
  output logic             a_pos,
  output logic             carry,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  state_e state, state_next;
  asel_e  sel;
  op_e    alu_op;

  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic             alu_ovf;

  logic [PW-1:0]    mul_m;
  logic [WIDTH-1:0] mul_q;
  logic [PW-1:0]    mul_p;
  logic [PW-1:0]    p_next;
  logic [CW-1:0]    count;
  logic             mul_start;
  logic             mul_last;

  assign sel    = asel_e'(a_sel);
  assign alu_op = op_e'(op);

  accum_alu #(.WIDTH(WIDTH)) u_alu (
    .a      (a_q),
    .b      (data_in),
    .op     (alu_op),
    .result (alu_result),
    .carry  (alu_carry),
    .ovf    (alu_ovf)
  );

  assign a_eq0  = (a_q == '0);
  assign a_pos  = ~a_q[WIDTH-1] && (a_q != '0);
  assign busy   = (state == ST_MUL);
  assign p_next = mul_q[0] ? (mul_p + mul_m) : mul_p;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    mul_start  = 1'b0;
    mul_last   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (a_load && (sel == ASEL_ALU) && (alu_op == OP_MUL) && (MUL_EN != 0)) begin
          mul_start  = 1'b1;
          state_next = ST_MUL;
        end
      end
      ST_MUL: begin
        // Fixed latency: the last iteration is always the WIDTH-th, whatever Q holds.
        if (count == CW'(1)) begin
          mul_last   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      out_q <= '0;
      carry <= 1'b0;
      ovf   <= 1'b0;
      done  <= 1'b0;
      mul_m <= '0;
      mul_q <= '0;
      mul_p <= '0;
      count <= '0;
    end else begin
      done <= mul_last;
      // out_q always captures the pre-edge accumulator, even alongside a load.
      if (out_load) out_q <= a_q;

      if (mul_start) begin
        mul_m <= {{WIDTH{1'b0}}, a_q};
        mul_q <= data_in;
        mul_p <= '0;
        count <= CW'(WIDTH);
      end else if (state == ST_MUL) begin
        mul_p <= p_next;
        mul_m <= mul_m << 1;
        mul_q <= mul_q >> 1;
        count <= count - CW'(1);
        if (mul_last) begin
          a_q   <= p_next[WIDTH-1:0];
          ovf   <= |p_next[PW-1:WIDTH];
          carry <= 1'b0;
        end
      end else if (a_load) begin
        case (sel)
          ASEL_EXT:  a_q <= ext_in;
          ASEL_DATA: a_q <= data_in;
          ASEL_ALU: begin
            a_q   <= alu_result;
            carry <= alu_carry;
            ovf   <= alu_ovf;
          end
          default: a_q <= a_q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_accum_unit.sv
// Directed testbench for accum_unit (WIDTH=8, MUL_EN=1) with hand-computed expectations.
module tb_accum_unit;
  import accum_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in, ext_in;
  logic [1:0] a_sel;
  logic [2:0] op;
  logic       a_load, out_load;
  logic [7:0] a_q, out_q;
  logic       a_eq0, a_pos, carry, ovf, busy, done;

  int total = 0;
  int bad   = 0;

  accum_unit #(.WIDTH(8), .MUL_EN(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .ext_in   (ext_in),
    .a_sel    (a_sel),
    .op       (op),
    .a_load   (a_load),
    .out_load (out_load),
    .a_q      (a_q),
    .out_q    (out_q),
    .a_eq0    (a_eq0),
    .a_pos    (a_pos),
    .carry    (carry),
    .ovf      (ovf),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ext(input logic [7:0] v);
    a_sel  = ASEL_EXT;
    ext_in = v;
    a_load = 1'b1;
    step();
    a_load = 1'b0;
  endtask

  task automatic alu_op(input op_e o, input logic [7:0] b);
    a_sel   = ASEL_ALU;
    op      = o;
    data_in = b;
    a_load  = 1'b1;
    step();
    a_load  = 1'b0;
  endtask

  task automatic start_mul(input logic [7:0] a, input logic [7:0] b);
    load_ext(a);
    a_sel   = ASEL_ALU;
    op      = OP_MUL;
    data_in = b;
    a_load  = 1'b1;
    step();
    a_load  = 1'b0;
  endtask

  // Returns the number of edges after the start edge until done is seen (bounded).
  task automatic wait_done(output int cycles, output int busy_cnt);
    cycles   = 0;
    busy_cnt = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && cycles < 20) begin
      step();
      out_load = 1'b0;
      cycles++;
      if (busy === 1'b1) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    data_in  = 8'($urandom);
    ext_in   = 8'($urandom);
    a_sel    = 2'($urandom);
    op       = 3'($urandom);
    a_load   = 1'b1;
    out_load = 1'b1;
    step();
    step();
    reset    = 1'b0;
    a_load   = 1'b0;
    out_load = 1'b0;
    total++; if (a_q !== 8'h00)  begin bad++; $display("FAIL reset_a_q got=%h exp=00", a_q); end
    total++; if (out_q !== 8'h00) begin bad++; $display("FAIL reset_out_q got=%h exp=00", out_q); end
    total++; if (a_eq0 !== 1'b1) begin bad++; $display("FAIL reset_a_eq0 got=%b exp=1", a_eq0); end
    total++; if (a_pos !== 1'b0) begin bad++; $display("FAIL reset_a_pos got=%b exp=0", a_pos); end
    total++; if (carry !== 1'b0) begin bad++; $display("FAIL reset_carry got=%b exp=0", carry); end
    total++; if (ovf !== 1'b0)   begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0)  begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
  endtask

  task automatic test_load_add();
    load_ext(8'd3);
    total++; if (a_q !== 8'd3)   begin bad++; $display("FAIL load_ext got=%h exp=03", a_q); end
    total++; if (a_pos !== 1'b1) begin bad++; $display("FAIL load_pos got=%b exp=1", a_pos); end
    alu_op(OP_ADD, 8'd1);
    total++; if (a_q !== 8'd4)   begin bad++; $display("FAIL add_3_1 got=%h exp=04", a_q); end
    total++; if ({carry, ovf} !== 2'b00) begin bad++; $display("FAIL add_3_1_flags got=%b exp=00", {carry, ovf}); end
    a_sel = ASEL_DATA; data_in = 8'h5A; a_load = 1'b1; step(); a_load = 1'b0;
    total++; if (a_q !== 8'h5A)  begin bad++; $display("FAIL load_data got=%h exp=5a", a_q); end
  endtask

  task automatic test_sub_flags();
    load_ext(8'd3);
    alu_op(OP_SUB, 8'd15);
    total++; if (a_q !== 8'hF4) begin bad++; $display("FAIL sub_3_15 got=%h exp=f4", a_q); end
    total++; if ({carry, ovf, a_pos, a_eq0} !== 4'b0000) begin
      bad++; $display("FAIL sub_3_15_flags c/o/pos/eq0 got=%b exp=0000", {carry, ovf, a_pos, a_eq0});
    end
    load_ext(8'h7F);
    alu_op(OP_ADD, 8'd1);
    total++; if (a_q !== 8'h80) begin bad++; $display("FAIL add_7f_1 got=%h exp=80", a_q); end
    total++; if ({carry, ovf} !== 2'b01) begin bad++; $display("FAIL add_7f_1_flags got=%b exp=01", {carry, ovf}); end
    load_ext(8'hFF);
    alu_op(OP_ADD, 8'd1);
    total++; if (a_q !== 8'h00) begin bad++; $display("FAIL add_ff_1 got=%h exp=00", a_q); end
    total++; if ({carry, ovf, a_eq0} !== 3'b101) begin bad++; $display("FAIL add_ff_1_flags got=%b exp=101", {carry, ovf, a_eq0}); end
    load_ext(8'd5);
    alu_op(OP_SUB, 8'd5);
    total++; if ({a_q, carry} !== {8'h00, 1'b1}) begin bad++; $display("FAIL sub_eq got=%h/%b exp=00/1", a_q, carry); end
    load_ext(8'h80);
    alu_op(OP_SUB, 8'd1);
    total++; if ({a_q, carry, ovf} !== {8'h7F, 1'b1, 1'b1}) begin
      bad++; $display("FAIL sub_80_1 got=%h/%b%b exp=7f/11", a_q, carry, ovf);
    end
    load_ext(8'hF0);
    alu_op(OP_AND, 8'h3C);
    total++; if ({a_q, carry, ovf} !== {8'h30, 2'b00}) begin
      bad++; $display("FAIL and got=%h/%b%b exp=30/00", a_q, carry, ovf);
    end
  endtask

  task automatic test_mul();
    int cyc, bcnt;
    load_ext(8'hFF);
    alu_op(OP_ADD, 8'd1);  // leaves carry=1 so MUL must clear it
    start_mul(8'd12, 8'd13);
    total++; if ({busy, done, a_q} !== {2'b10, 8'd12}) begin
      bad++; $display("FAIL mul_start busy/done/a_q got=%b%b/%h exp=10/0c", busy, done, a_q);
    end
    wait_done(cyc, bcnt);
    total++; if (cyc !== 8)  begin bad++; $display("FAIL mul_latency got=%0d exp=8", cyc); end
    total++; if (bcnt !== 8) begin bad++; $display("FAIL mul_busy_cycles got=%0d exp=8", bcnt); end
    total++; if ({a_q, ovf, carry, busy} !== {8'd156, 3'b000}) begin
      bad++; $display("FAIL mul_12_13 got=%h/%b%b%b exp=9c/000", a_q, ovf, carry, busy);
    end
    step();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL mul_done_pulse got=%b exp=0", done); end

    start_mul(8'd20, 8'd20);
    a_sel = ASEL_EXT; ext_in = 8'h55; a_load = 1'b1; out_load = 1'b1;
    wait_done(cyc, bcnt);
    a_load = 1'b0;
    total++; if (cyc !== 8) begin bad++; $display("FAIL mul2_latency got=%0d exp=8", cyc); end
    total++; if ({a_q, ovf} !== {8'h90, 1'b1}) begin bad++; $display("FAIL mul_20_20 got=%h/%b exp=90/1", a_q, ovf); end
    total++; if (out_q !== 8'd20) begin bad++; $display("FAIL mul_out_load got=%h exp=14", out_q); end

    start_mul(8'hAB, 8'd1);
    wait_done(cyc, bcnt);
    total++; if ({cyc, a_q, ovf} !== {32'd8, 8'hAB, 1'b0}) begin
      bad++; $display("FAIL mul_by_1 cyc/a_q/ovf got=%0d/%h/%b exp=8/ab/0", cyc, a_q, ovf);
    end
  endtask

  task automatic test_mul_abort();
    int cyc, bcnt, dcnt;
    start_mul(8'd7, 8'd3);
    step(); step(); step();  // now in the 4th busy cycle
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_busy_before got=%b exp=1", busy); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if ({a_q, busy, done} !== {8'h00, 2'b00}) begin
      bad++; $display("FAIL abort_state a_q/busy/done got=%h/%b%b exp=00/00", a_q, busy, done);
    end
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done === 1'b1) dcnt++;
    end
    total++; if ({dcnt, a_q} !== {32'd0, 8'h00}) begin
      bad++; $display("FAIL abort_no_done done_cnt/a_q got=%0d/%h exp=0/00", dcnt, a_q);
    end
    start_mul(8'd6, 8'd7);
    wait_done(cyc, bcnt);
    total++; if ({cyc, a_q, ovf} !== {32'd8, 8'd42, 1'b0}) begin
      bad++; $display("FAIL mul_after_abort cyc/a_q/ovf got=%0d/%h/%b exp=8/2a/0", cyc, a_q, ovf);
    end
  endtask

  task automatic test_shift_hold_out();
    load_ext(8'h81);
    alu_op(OP_SHL, 8'h00);
    total++; if ({a_q, carry, ovf} !== {8'h02, 2'b10}) begin
      bad++; $display("FAIL shl got=%h/%b%b exp=02/10", a_q, carry, ovf);
    end
    alu_op(OP_SHR, 8'h00);
    total++; if ({a_q, carry} !== {8'h01, 1'b0}) begin bad++; $display("FAIL shr got=%h/%b exp=01/0", a_q, carry); end
    a_sel = ASEL_HOLD; data_in = 8'hEE; ext_in = 8'hDD; a_load = 1'b1; step(); a_load = 1'b0;
    total++; if (a_q !== 8'h01) begin bad++; $display("FAIL hold got=%h exp=01", a_q); end
    a_sel = ASEL_EXT; ext_in = 8'd9; a_load = 1'b1; out_load = 1'b1; step(); a_load = 1'b0; out_load = 1'b0;
    total++; if ({out_q, a_q} !== {8'h01, 8'h09}) begin
      bad++; $display("FAIL load_and_out out_q/a_q got=%h/%h exp=01/09", out_q, a_q);
    end
    alu_op(OP_OR, 8'h30);
    total++; if (a_q !== 8'h39) begin bad++; $display("FAIL or got=%h exp=39", a_q); end
    alu_op(OP_PASS, 8'hC5);
    total++; if ({a_q, a_pos} !== {8'hC5, 1'b0}) begin bad++; $display("FAIL pass got=%h/%b exp=c5/0", a_q, a_pos); end
    out_load = 1'b1; step(); out_load = 1'b0;
    total++; if (out_q !== 8'hC5) begin bad++; $display("FAIL out_load got=%h exp=c5", out_q); end
  endtask

  initial begin
    data_in  = '0;
    ext_in   = '0;
    a_sel    = '0;
    op       = '0;
    a_load   = 1'b0;
    out_load = 1'b0;
    test_reset();
    test_load_add();
    test_sub_flags();
    test_mul();
    test_mul_abort();
    test_shift_hold_out();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/accum_unit.md
Name: accum_unit

Overview:
Parametrised successor to the processor's A (accumulator) register. Holds a WIDTH-bit accumulator and selects its next value from external input, data bus or an internal ALU. The ALU adds add/sub/logic/shift ops and an iterative shift-and-add multiply with a busy/done handshake. Also produces status flags and a separately loaded output register. Sits in the datapath between the data bus, the controller FSM and the output port.

Parameters:
WIDTH, 8, accumulator/operand/output width in bits (>=4)
MUL_EN, 1, 1 = MUL op implemented; 0 = MUL behaves as ADD, busy never asserts

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
data_in  in  WIDTH  data bus; ALU operand B; load source for a_sel=10
ext_in  in  WIDTH  external input; load source for a_sel=01
a_sel  in  2  next-value select: 00 ALU result, 01 ext_in, 10 data_in, 11 hold
op  in  3  ALU op: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SHL, 101 SHR (logical), 110 MUL, 111 PASS B
a_load  in  1  load strobe for accumulator
out_load  in  1  copy accumulator to out_q
a_q  out  WIDTH  accumulator value
out_q  out  WIDTH  output register
a_eq0  out  1  a_q == 0
a_pos  out  1  a_q[WIDTH-1]==0 and a_q!=0
carry  out  1  registered carry flag
ovf  out  1  registered overflow flag
busy  out  1  multiply in progress
done  out  1  one-cycle pulse, multiply result written

Behaviour:
- Interface fixed: one clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset (sampled high at an edge) clears all state: a_q=0, out_q=0, carry=0, ovf=0, busy=0, done=0, FSM=IDLE. Reset overrides every other input, including a multiply in progress. An aborted multiply produces no done pulse.
- a_eq0 and a_pos are combinational from a_q. With a_q=0 after reset: a_eq0=1, a_pos=0.
- FSM states: IDLE, MUL.
- IDLE, a_load=1:
  - a_sel=01 loads ext_in; a_sel=10 loads data_in. Flags unchanged.
  - a_sel=11 holds a_q. Flags unchanged.
  - a_sel=00 with a non-MUL op loads the ALU result at the same edge (latency 1) and updates carry/ovf.
- Flag rules for a_sel=00 loads:
  - ADD: carry = carry-out; ovf = signed overflow.
  - SUB (A-B): carry = no-borrow (A>=B unsigned); ovf = signed overflow.
  - AND, OR, PASS: carry=0, ovf=0.
  - SHL: carry = A[WIDTH-1], ovf=0. SHR: carry = A[0], ovf=0.
- MUL start (a_sel=00, op=MUL, a_load=1 at edge k, MUL_EN=1):
  - Latch multiplicand M=a_q (zero-extended to 2*WIDTH), multiplier Q=data_in, product P=0, count=WIDTH.
  - busy=1 from edge k. a_q holds its old value during MUL.
- MUL iteration, edges k+1..k+WIDTH: if Q[0], P+=M; then M<<=1, Q>>=1, count-=1.
- MUL finish, edge k+WIDTH:
  - a_q=P[WIDTH-1:0]; ovf = |P[2*WIDTH-1:WIDTH] (unsigned); carry=0.
  - busy=0; done=1 for exactly that cycle. State returns to IDLE.
- While busy, a_load is ignored completely. out_load still works and copies the current (old) a_q.
- Multiply by 0 or by 1 still takes the full WIDTH cycles; latency is fixed.
- out_load=1 at an edge gives out_q = a_q value before that edge. With a_load and out_load in the same cycle, out_q gets the old a_q.
- All arithmetic is modulo 2^WIDTH; no saturation.

Decomposition:
- Package accum_pkg holds: op encodings (OP_ADD..OP_PASS), a_sel encodings (ASEL_ALU, ASEL_EXT, ASEL_DATA, ASEL_HOLD), FSM state typedef.
- One sub-module: accum_alu. It is combinational, parametrised by WIDTH, and returns result, carry and ovf for the single-cycle ops.
- accum_unit owns the registers, multiply FSM and datapath.

Test Plan:
- Reset: hold reset=1 for 2 edges with random inputs -> a_q=0, out_q=0, a_eq0=1, a_pos=0, carry=0, ovf=0, busy=0.
- Load/ADD: a_sel=01, ext_in=3, a_load -> a_q=3, a_pos=1. Then a_sel=00, ADD, data_in=1 -> a_q=4, carry=0, ovf=0.
- SUB/flags:
  - a_q=3, SUB, data_in=15 -> a_q=0xF4, carry=0, a_pos=0, a_eq0=0.
  - a_q=0x7F, ADD, data_in=1 -> a_q=0x80, ovf=1.
  - a_q=0xFF, ADD, data_in=1 -> a_q=0, carry=1, a_eq0=1.
- MUL, WIDTH=8:
  - a_q=12, data_in=13 -> busy for 8 cycles; a_q=156, ovf=0, done high exactly 1 cycle.
  - a_q=20, data_in=20 -> a_q=0x90, ovf=1.
  - a_load with a_sel=01 while busy -> ignored, final a_q=0x90.
- Reset mid-multiply: assert reset at the 4th busy cycle -> a_q=0, busy=0, no done pulse. The next MUL works normally.
- Shift/hold/output:
  - a_q=0x81, SHL -> a_q=0x02, carry=1.
  - SHR -> a_q=0x01, carry=0.
  - a_sel=11 with a_load -> unchanged.
  - a_load (01, ext_in=9) plus out_load in the same cycle -> out_q=0x01, a_q=9.
